riscv_mstage_lsu: RTL and testbench
===================================

Name: riscv_mstage_lsu

Overview:
Memory-stage load/store unit that consumes the M-stage outputs of the execute/memory pipeline register. It drives a single-outstanding data-memory request/grant/response bus and detects misaligned accesses. It extends load data for the memory/writeback register, raises access faults toward the trap logic, and generates the stall that holds the execute/memory register and everything upstream of it.

Parameters:
XLEN, 64, data/address width
TIMEOUT, 255, cycles in REQ+RESP before access fault; counter width is $clog2(TIMEOUT+1)

Ports:
i_riscv_em_clk  in  1  clock
i_riscv_em_rst  in  1  asynchronous, active-high reset
i_riscv_mlsu_load_m  in  1  M-stage instruction is a load
i_riscv_mlsu_store_m  in  1  M-stage instruction is a store
i_riscv_mlsu_storesrc_m  in  2  store size: 00 byte, 01 half, 10 word, 11 double
i_riscv_mlsu_memext_m  in  3  load type: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu, 111 treated as ld
i_riscv_mlsu_addr_m  in  XLEN  effective address (ALU result)
i_riscv_mlsu_storedata_m  in  XLEN  store data, LSB-aligned
i_riscv_mlsu_kill_m  in  1  trap/flush: suppress or abandon the access
o_dmem_req  out  1  bus request
o_dmem_we  out  1  write enable
o_dmem_addr  out  XLEN  doubleword-aligned address {addr[63:3],3'b0}
o_dmem_be  out  8  byte enables
o_dmem_wdata  out  XLEN  lane-replicated store data
i_dmem_gnt  in  1  request accepted
i_dmem_rvalid  in  1  response valid (loads and store acks)
i_dmem_rdata  in  XLEN  read data
i_dmem_err  in  1  bus error, qualified by rvalid
o_riscv_mlsu_stall  out  1  hold the execute/memory register and upstream stages
o_riscv_mlsu_loaddata_m  out  XLEN  extended load result
o_riscv_mlsu_load_misaligned_m  out  1  load address misaligned
o_riscv_mlsu_store_misaligned_m  out  1  store address misaligned
o_riscv_mlsu_access_fault_m  out  1  bus error or timeout
o_riscv_mlsu_done_m  out  1  one-cycle completion pulse

Behaviour:
- Alignment and access qualification:
  - Access is valid when load or store is set; load wins if both are set.
  - Misaligned: half with addr[0]!=0; word with addr[1:0]!=0; double with addr[2:0]!=0.
  - Misaligned flags are combinational, asserted only while an access is present and kill=0.
  - A misaligned access issues no bus cycle and raises no stall.
- Start condition: an access starts only when valid, aligned, kill=0 and state=IDLE.
- FSM states and transitions:
  - IDLE: stall=start. On start, latch addr, we, be, wdata, memext → REQ; counter cleared.
  - REQ: req=1, address/control held stable until gnt. On gnt → RESP. On kill before gnt → IDLE (request withdrawn).
  - RESP: wait for rvalid; rvalid is never accepted in the gnt cycle. On rvalid → DONE, latching rdata and err. If kill was seen after gnt, set sticky drop; then on rvalid → IDLE with no done, no fault and data discarded.
  - DONE: stall=0, done=1, loaddata valid, fault=err|timeout → IDLE next cycle.
- Stall: 1 in REQ and in RESP (including drop), 0 in DONE.
- Timeout: counter increments every cycle in REQ/RESP. On reaching TIMEOUT → DONE with fault=1; req drops and any late rvalid is ignored.
- Store data path:
  - be = size mask (0x01/0x03/0x0F/0xFF) << addr[2:0].
  - wdata replicates the byte/half/word across all lanes; double passes through.
- Load extension: selects lane addr[2:0] of the latched rdata, then sign- or zero-extends per memext. Loaddata is 0 when not in DONE.
- Latency with zero-wait gnt and rvalid one cycle after gnt:
  - Access presented cycle 0; req in cycle 1; rvalid in cycle 2; DONE in cycle 3.
  - Stall is high for cycles 0–2; the execute/memory register advances at the end of cycle 3.
- Reset: state IDLE, counter 0, drop 0, latched registers 0. All outputs 0, regardless of state at the time of reset. An in-flight bus transaction is abandoned.

Test Plan:
- ld from addr 0x1000, rdata=0x8877665544332211 with rvalid one cycle after gnt → stall 3 cycles, loaddata=0x8877665544332211, done=1 for one cycle.
- lb from 0x1007 with rdata[63:56]=0x80 → be unused, loaddata=0xFFFFFFFFFFFFFF80. lbu from the same address → 0x80.
- sh to 0x1006, data 0xABCD → be=0xC0, wdata=0xABCDABCDABCDABCD, we=1, done on ack.
- lw at 0x1002 → load_misaligned=1, req never asserted, stall=0.
- gnt withheld for 255 cycles → access_fault=1 in DONE, stall released.
- kill asserted after gnt, rvalid 2 cycles later → no done, no fault, FSM returns to IDLE. Repeat with reset asserted mid-RESP → all outputs 0 immediately.

Source files
------------

// File: rtl/riscv_mstage_lsu.sv
// rtl/riscv_mstage_lsu.sv - M-stage load/store unit: single-outstanding dmem bus, alignment check, load extension, stall
module riscv_mstage_lsu #(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 255
) (
    input  logic            i_riscv_em_clk,
    input  logic            i_riscv_em_rst,
    input  logic            i_riscv_mlsu_load_m,
    input  logic            i_riscv_mlsu_store_m,
    input  logic [1:0]      i_riscv_mlsu_storesrc_m,
    input  logic [2:0]      i_riscv_mlsu_memext_m,
    input  logic [XLEN-1:0] i_riscv_mlsu_addr_m,
    input  logic [XLEN-1:0] i_riscv_mlsu_storedata_m,
    input  logic            i_riscv_mlsu_kill_m,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [7:0]      o_dmem_be,
    output logic [XLEN-1:0] o_dmem_wdata,
    input  logic            i_dmem_gnt,
    input  logic            i_dmem_rvalid,
    input  logic [XLEN-1:0] i_dmem_rdata,
    input  logic            i_dmem_err,
    output logic            o_riscv_mlsu_stall,
    output logic [XLEN-1:0] o_riscv_mlsu_loaddata_m,
    output logic            o_riscv_mlsu_load_misaligned_m,
    output logic            o_riscv_mlsu_store_misaligned_m,
    output logic            o_riscv_mlsu_access_fault_m,
    output logic            o_riscv_mlsu_done_m
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              active, misaligned, start, timeout_hit, drop_now;
    logic [1:0]        size;
    logic [7:0]        be_d;
    logic [XLEN-1:0]   wdata_d, lane;
    logic [CW-1:0]     cnt_q;
    logic              drop_q, we_q, err_q, tout_q;
    logic [7:0]        be_q;
    logic [2:0]        memext_q;
    logic [XLEN-1:0]   addr_q, wdata_q, rdata_q;

    // memext[1:0] already encodes the load size, including 111 as a double
    assign size   = i_riscv_mlsu_load_m ? i_riscv_mlsu_memext_m[1:0] : i_riscv_mlsu_storesrc_m;
    assign active = (i_riscv_mlsu_load_m | i_riscv_mlsu_store_m) & ~i_riscv_mlsu_kill_m & ~i_riscv_em_rst;

    always_comb begin
        misaligned = 1'b0;
        be_d       = 8'h01;
        wdata_d    = i_riscv_mlsu_storedata_m;
        case (size)
            2'b00: begin
                be_d    = 8'h01;
                wdata_d = {(XLEN/8){i_riscv_mlsu_storedata_m[7:0]}};
            end
            2'b01: begin
                misaligned = i_riscv_mlsu_addr_m[0];
                be_d       = 8'h03;
                wdata_d    = {(XLEN/16){i_riscv_mlsu_storedata_m[15:0]}};
            end
            2'b10: begin
                misaligned = |i_riscv_mlsu_addr_m[1:0];
                be_d       = 8'h0F;
                wdata_d    = {(XLEN/32){i_riscv_mlsu_storedata_m[31:0]}};
            end
            default: begin
                misaligned = |i_riscv_mlsu_addr_m[2:0];
                be_d       = 8'hFF;
            end
        endcase
        be_d = be_d << i_riscv_mlsu_addr_m[2:0];
    end

    assign o_riscv_mlsu_load_misaligned_m  = active & i_riscv_mlsu_load_m & misaligned;
    assign o_riscv_mlsu_store_misaligned_m = active & ~i_riscv_mlsu_load_m & misaligned;
    assign start       = active & ~misaligned & (state_q == S_IDLE);
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
    assign drop_now    = drop_q | i_riscv_mlsu_kill_m;

    always_ff @(posedge i_riscv_em_clk or posedge i_riscv_em_rst) begin
        if (i_riscv_em_rst) state_q <= S_IDLE;
        else                state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_REQ;
            S_REQ: begin
                if (i_riscv_mlsu_kill_m)  state_d = S_IDLE;
                else if (i_dmem_gnt)      state_d = S_RESP;
                else if (timeout_hit)     state_d = S_DONE;
            end
            S_RESP: begin
                if (i_dmem_rvalid || timeout_hit) state_d = drop_now ? S_IDLE : S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_riscv_em_clk or posedge i_riscv_em_rst) begin
        if (i_riscv_em_rst) begin
            cnt_q    <= '0;
            drop_q   <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            tout_q   <= 1'b0;
            be_q     <= '0;
            memext_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            if (start) begin
                cnt_q    <= '0;
                drop_q   <= 1'b0;
                err_q    <= 1'b0;
                tout_q   <= 1'b0;
                we_q     <= ~i_riscv_mlsu_load_m;
                be_q     <= be_d;
                memext_q <= i_riscv_mlsu_memext_m;
                addr_q   <= i_riscv_mlsu_addr_m;
                wdata_q  <= wdata_d;
            end else if (state_q == S_REQ || state_q == S_RESP) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == S_RESP && i_riscv_mlsu_kill_m) drop_q <= 1'b1;
            if (state_q == S_RESP && i_dmem_rvalid) begin
                rdata_q <= i_dmem_rdata;
                err_q   <= i_dmem_err;
            end
            // DONE reached without an accepted response can only be a timeout
            if (state_d == S_DONE && state_q != S_DONE && !(state_q == S_RESP && i_dmem_rvalid))
                tout_q <= 1'b1;
        end
    end

    assign lane = rdata_q >> {addr_q[2:0], 3'b000};

    always_comb begin
        o_dmem_req                  = 1'b0;
        o_riscv_mlsu_stall          = 1'b0;
        o_riscv_mlsu_done_m         = 1'b0;
        o_riscv_mlsu_access_fault_m = 1'b0;
        o_riscv_mlsu_loaddata_m     = '0;
        case (state_q)
            S_IDLE: o_riscv_mlsu_stall = start;
            S_REQ: begin
                o_dmem_req         = 1'b1;
                o_riscv_mlsu_stall = 1'b1;
            end
            S_RESP: o_riscv_mlsu_stall = 1'b1;
            default: begin
                o_riscv_mlsu_done_m         = 1'b1;
                o_riscv_mlsu_access_fault_m = err_q | tout_q;
                case (memext_q)
                    3'b000:  o_riscv_mlsu_loaddata_m = {{(XLEN-8){lane[7]}}, lane[7:0]};
                    3'b001:  o_riscv_mlsu_loaddata_m = {{(XLEN-16){lane[15]}}, lane[15:0]};
                    3'b010:  o_riscv_mlsu_loaddata_m = {{(XLEN-32){lane[31]}}, lane[31:0]};
                    3'b100:  o_riscv_mlsu_loaddata_m = {{(XLEN-8){1'b0}}, lane[7:0]};
                    3'b101:  o_riscv_mlsu_loaddata_m = {{(XLEN-16){1'b0}}, lane[15:0]};
                    3'b110:  o_riscv_mlsu_loaddata_m = {{(XLEN-32){1'b0}}, lane[31:0]};
                    default: o_riscv_mlsu_loaddata_m = lane;
                endcase
            end
        endcase
    end

    assign o_dmem_we    = o_dmem_req & we_q;
    assign o_dmem_addr  = o_dmem_req ? {addr_q[XLEN-1:3], 3'b000} : '0;
    assign o_dmem_be    = o_dmem_req ? be_q : '0;
    assign o_dmem_wdata = o_dmem_req ? wdata_q : '0;
endmodule

// File: tb/tb_riscv_mstage_lsu.sv
// tb/tb_riscv_mstage_lsu.sv - directed self-checking bench for riscv_mstage_lsu
module tb_riscv_mstage_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        load, store, kill;
    logic [1:0]  storesrc;
    logic [2:0]  memext;
    logic [63:0] addr_m, sdata;
    logic        req, we, gnt, rvalid, err;
    logic [63:0] addr, wdata, rdata, loaddata;
    logic [7:0]  be;
    logic        stall, ld_mis, st_mis, fault, done;

    int errors = 0;
    int checks = 0;

    logic [63:0] obs_ld, obs_wd, obs_addr;
    logic [7:0]  obs_be;
    logic        obs_we, obs_dn, obs_flt, obs_exit;
    int          obs_st, obs_reqn;

    always #5 clk = ~clk;

    riscv_mstage_lsu dut (
        .i_riscv_em_clk                  (clk),
        .i_riscv_em_rst                  (rst),
        .i_riscv_mlsu_load_m             (load),
        .i_riscv_mlsu_store_m            (store),
        .i_riscv_mlsu_storesrc_m         (storesrc),
        .i_riscv_mlsu_memext_m           (memext),
        .i_riscv_mlsu_addr_m             (addr_m),
        .i_riscv_mlsu_storedata_m        (sdata),
        .i_riscv_mlsu_kill_m             (kill),
        .o_dmem_req                      (req),
        .o_dmem_we                       (we),
        .o_dmem_addr                     (addr),
        .o_dmem_be                       (be),
        .o_dmem_wdata                    (wdata),
        .i_dmem_gnt                      (gnt),
        .i_dmem_rvalid                   (rvalid),
        .i_dmem_rdata                    (rdata),
        .i_dmem_err                      (err),
        .o_riscv_mlsu_stall              (stall),
        .o_riscv_mlsu_loaddata_m         (loaddata),
        .o_riscv_mlsu_load_misaligned_m  (ld_mis),
        .o_riscv_mlsu_store_misaligned_m (st_mis),
        .o_riscv_mlsu_access_fault_m     (fault),
        .o_riscv_mlsu_done_m             (done)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic present(input logic ld, input logic st, input logic [1:0] ss, input logic [2:0] me,
                           input logic [63:0] a, input logic [63:0] sd);
        @(posedge clk);
        #1;
        load = ld; store = st; storesrc = ss; memext = me; addr_m = a; sdata = sd; kill = 1'b0;
    endtask

    task automatic idle();
        load = 1'b0; store = 1'b0; kill = 1'b0; addr_m = '0; sdata = '0;
    endtask

    // Bus responder: grant after gw waiting REQ cycles, respond rw cycles after the cycle following gnt
    task automatic run_bus(input int gw, input int rw, input logic [63:0] rd, input logic er, input bit kill_after);
        int gcnt, rcnt;
        bit pending, seen_req;
        gcnt = 0; rcnt = 0; pending = 0; seen_req = 0;
        obs_st = 0; obs_dn = 0; obs_ld = '0; obs_flt = 0; obs_exit = 0; obs_reqn = 0;
        obs_be = '0; obs_wd = '0; obs_we = 0; obs_addr = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            gnt = 0; rvalid = 0; rdata = '0; err = 0;
            if (stall) obs_st++;
            if (seen_req && !stall) begin
                obs_exit = 1; obs_dn = done; obs_ld = loaddata; obs_flt = fault;
                break;
            end
            if (pending) begin
                if (kill_after) kill = 1'b1;
                if (rcnt >= rw) begin
                    rvalid = 1; rdata = rd; err = er; pending = 0;
                end else rcnt++;
            end
            if (req) begin
                if (!seen_req) begin
                    obs_be = be; obs_wd = wdata; obs_we = we; obs_addr = addr;
                end
                seen_req = 1;
                obs_reqn++;
                if (gcnt >= gw) begin
                    gnt = 1; pending = 1;
                end else gcnt++;
            end
        end
        check("bus_exit", 64'(obs_exit), 64'd1);
    endtask

    initial begin
        rst = 1'b1; gnt = 0; rvalid = 0; rdata = '0; err = 0;
        storesrc = '0; memext = '0;
        idle();
        repeat (2) @(negedge clk);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_req", 64'(req), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b0;

        // ld, zero-wait grant, response one cycle later
        present(1, 0, 2'b00, 3'b011, 64'h1000, '0);
        run_bus(0, 0, 64'h8877665544332211, 0, 0);
        check("ld_stall_cycles", 64'(obs_st), 64'd3);
        check("ld_done", 64'(obs_dn), 64'd1);
        check("ld_data", obs_ld, 64'h8877665544332211);
        check("ld_addr", obs_addr, 64'h1000);
        check("ld_we", 64'(obs_we), 64'd0);
        check("ld_fault", 64'(obs_flt), 64'd0);
        idle();
        @(negedge clk);
        check("ld_done_pulse", 64'(done), 64'd0);
        check("ld_loaddata_idle", loaddata, 64'd0);

        // lb / lbu from top byte
        present(1, 0, 2'b00, 3'b000, 64'h1007, '0);
        run_bus(0, 0, 64'h8000_0000_0000_0011, 0, 0);
        check("lb_data", obs_ld, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_addr", obs_addr, 64'h1000);
        idle();
        present(1, 0, 2'b00, 3'b100, 64'h1007, '0);
        run_bus(0, 0, 64'h8000_0000_0000_0011, 0, 0);
        check("lbu_data", obs_ld, 64'h80);
        idle();

        // lw / lwu from upper word with wait states
        present(1, 0, 2'b00, 3'b010, 64'h2004, '0);
        run_bus(2, 3, 64'h8000_0000_1234_5678, 0, 0);
        check("lw_stall_cycles", 64'(obs_st), 64'd8);
        check("lw_data", obs_ld, 64'hFFFF_FFFF_8000_0000);
        idle();
        present(1, 0, 2'b00, 3'b110, 64'h2004, '0);
        run_bus(0, 0, 64'h8000_0000_1234_5678, 0, 0);
        check("lwu_data", obs_ld, 64'h0000_0000_8000_0000);
        idle();

        // sh to 0x1006
        present(0, 1, 2'b01, 3'b000, 64'h1006, 64'hABCD);
        run_bus(0, 0, '0, 0, 0);
        check("sh_be", 64'(obs_be), 64'hC0);
        check("sh_wdata", obs_wd, 64'hABCD_ABCD_ABCD_ABCD);
        check("sh_we", 64'(obs_we), 64'd1);
        check("sh_done", 64'(obs_dn), 64'd1);
        idle();

        // sw with bus error
        present(0, 1, 2'b10, 3'b000, 64'h2004, 64'h1122_3344);
        run_bus(0, 1, '0, 1, 0);
        check("sw_be", 64'(obs_be), 64'hF0);
        check("sw_wdata", obs_wd, 64'h1122_3344_1122_3344);
        check("sw_err_fault", 64'(obs_flt), 64'd1);
        idle();

        // misaligned accesses
        present(1, 0, 2'b00, 3'b010, 64'h1002, '0);
        @(negedge clk);
        check("lw_mis_flag", 64'(ld_mis), 64'd1);
        check("lw_mis_stflag", 64'(st_mis), 64'd0);
        check("lw_mis_stall", 64'(stall), 64'd0);
        check("lw_mis_req", 64'(req), 64'd0);
        @(negedge clk);
        check("lw_mis_req_later", 64'(req), 64'd0);
        kill = 1'b1;
        #1;
        check("lw_mis_killed", 64'(ld_mis), 64'd0);
        idle();
        present(0, 1, 2'b11, 3'b000, 64'h1004, '0);
        @(negedge clk);
        check("sd_mis_flag", 64'(st_mis), 64'd1);
        check("sd_mis_ldflag", 64'(ld_mis), 64'd0);
        idle();

        // grant withheld: timeout
        present(1, 0, 2'b00, 3'b011, 64'h3000, '0);
        run_bus(100000, 0, '0, 0, 0);
        check("to_done", 64'(obs_dn), 64'd1);
        check("to_fault", 64'(obs_flt), 64'd1);
        check("to_req_cycles", 64'(obs_reqn), 64'd255);
        check("to_stall_cycles", 64'(obs_st), 64'd256);
        idle();

        // kill after grant: dropped response
        present(1, 0, 2'b00, 3'b011, 64'h4000, '0);
        run_bus(0, 2, 64'hDEAD_BEEF, 1, 1);
        check("drop_done", 64'(obs_dn), 64'd0);
        check("drop_fault", 64'(obs_flt), 64'd0);
        check("drop_stall_cycles", 64'(obs_st), 64'd5);
        idle();
        present(1, 0, 2'b00, 3'b010, 64'h1008, '0);
        run_bus(0, 0, 64'h0000_0000_7FFF_FFFF, 0, 0);
        check("after_drop_data", obs_ld, 64'h7FFF_FFFF);
        idle();

        // reset mid-RESP with kill pending
        present(1, 0, 2'b00, 3'b011, 64'h5000, '0);
        @(negedge clk);
        @(negedge clk);
        check("rr_req", 64'(req), 64'd1);
        gnt = 1;
        @(negedge clk);
        gnt = 0;
        kill = 1'b1;
        check("rr_resp_stall", 64'(stall), 64'd1);
        kill = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rr_stall", 64'(stall), 64'd0);
        check("rr_req0", 64'(req), 64'd0);
        check("rr_outs", {be, 55'd0, we, done, fault, ld_mis, st_mis, 3'd0}, 64'd0);
        check("rr_addr", addr, 64'd0);
        check("rr_wdata", wdata, 64'd0);
        check("rr_loaddata", loaddata, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        present(1, 0, 2'b00, 3'b001, 64'h1002, '0);
        run_bus(0, 0, 64'h0000_0000_8001_0000, 0, 0);
        check("rr_recover_lh", obs_ld, 64'hFFFF_FFFF_FFFF_8001);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
